fx2_slave_fifo_arb: RTL and testbench
=====================================

Name: fx2_slave_fifo_arb

Overview:
- Parametrised next-generation controller for the FX2 Slave FIFO interface.
- Moves words bidirectionally between the external FIFO bus (FD) and local message logic.
- Adds, as new behaviour: configurable data width and endpoint addresses, bounded bursts with round-robin fairness between read and write, streaming handshakes, explicit bus-direction control, and end-of-message PKTEND commit.
- Sits between the FX2 pins and the local TX message FIFO / RX message parser.

Parameters:
- DW, 16: FD / data-path width in bits.
- RD_EP_ADR, 2'b00: FIFOADR value for the OUT (host-to-FPGA) endpoint.
- WR_EP_ADR, 2'b10: FIFOADR value for the IN (FPGA-to-host) endpoint.
- MAX_BURST, 256: maximum words per grant before returning to IDLE (1..65535).
- PKT_TIMEOUT, 1024: idle cycles before forced PKTEND; used only with the optional feature.

Ports:
- CLK  in  1  interface clock (IFCLK domain).
- RST  in  1  asynchronous, active-low reset.
- FLAG_EMPTY  in  1  high = read endpoint empty.
- FLAG_FULL  in  1  high = write endpoint full.
- FD  inout  DW  Slave FIFO data bus.
- tx_data  in  DW  word to write; valid while tx_valid=1.
- tx_valid  in  1  local TX word available.
- tx_last  in  1  qualifies tx_data as the last word of a message.
- tx_ready  out  1  one-cycle pop strobe; the word is consumed on this cycle.
- rx_data  out  DW  captured read word.
- rx_valid  out  1  one-cycle strobe; rx_data is valid.
- SLOE  out  1  high = FX2 drives FD (read mode).
- SLRD  out  1  read strobe, active-high pulse.
- SLWR  out  1  write strobe, active-high pulse.
- FIFOADR  out  2  endpoint select.
- PKTEND  out  1  packet commit, active-high pulse.
- state_monitor  out  3  current state encoding.

Behaviour:
- Reset (RST=0, asynchronous):
  - State = IDLE.
  - SLOE, SLRD, SLWR, PKTEND, tx_ready, rx_valid = 0; rx_data = 0; FIFOADR = RD_EP_ADR.
  - Burst counter = 0; last_grant = WRITE, so read wins the first contest.
  - FD hi-z.
  - Reset mid-burst abandons the transfer. A strobe in flight is cleared asynchronously.
- FD direction:
  - FD is driven from an internal DW-bit out register only in states WR_STB and WR_GAP.
  - FD is hi-z in all other states. SLOE never overlaps FPGA drive.
- States: IDLE=0, RD_OE=1, RD_CHK=2, RD_STB=3, WR_STB=4, WR_GAP=5, PKT=6.
- IDLE:
  - rd_req = !FLAG_EMPTY; wr_req = !FLAG_FULL & tx_valid.
  - If both requests are set, grant the side opposite last_grant. Otherwise grant whichever is set.
  - On a read grant: FIFOADR<=RD_EP_ADR, cnt<=0, last_grant<=READ, go to RD_OE.
  - On a write grant: FIFOADR<=WR_EP_ADR, out register<=tx_data, tx_ready pulse, SLWR<=1, cnt<=1, last_grant<=WRITE, go to WR_STB.
- Read path:
  - RD_OE: SLOE<=1 (address settle), then RD_CHK.
  - RD_CHK, if !FLAG_EMPTY and cnt<MAX_BURST: rx_data<=FD, rx_valid pulse, SLRD<=1, go to RD_STB.
  - RD_CHK otherwise: SLOE<=0, go to IDLE.
  - RD_STB: SLRD<=0, cnt<=cnt+1, go to RD_CHK.
  - Minimum 2 clocks per read word.
- Write path:
  - WR_STB: SLWR<=0. If the word just written had tx_last=1, go to PKT; else go to WR_GAP.
  - WR_GAP: FLAG_FULL=1 means wait; do not exit.
  - WR_GAP, if !FLAG_FULL & tx_valid & cnt<MAX_BURST: load the next word, pulse tx_ready, SLWR<=1, cnt++, go to WR_STB.
  - WR_GAP, if !FLAG_FULL and (!tx_valid or cnt==MAX_BURST): go to IDLE.
  - PKT: PKTEND=1 for exactly one cycle, then IDLE.
  - tx_last is sampled together with tx_data at the pop.
- Counter: 16-bit. It saturates and never wraps. Reaching MAX_BURST forces IDLE so the other side is arbitrated.
- Outputs SLOE, SLRD, SLWR, PKTEND, FIFOADR are registered; no combinational path from flags to pins.

Optional Feature:
- Macro: FX2_PKTEND_TIMEOUT_EN.
- Defined: a counter tracks cycles in IDLE since the last SLWR whose word had tx_last=0. When the count reaches PKT_TIMEOUT, the block enters PKT and pulses PKTEND once, committing the short packet. The counter is cleared by any write or PKTEND.
- Undefined: PKTEND is asserted only after tx_last, and the timeout counter is absent.

Test Plan:
- Reset: hold RST=0 with FLAG_EMPTY=0, tx_valid=1 -> all strobes 0, FD hi-z, state_monitor=0. Release -> read granted first, FIFOADR=00.
- Read burst: FX2 model holds 5 words 0x1111..0x5555, FLAG_EMPTY rises after the 5th -> exactly 5 rx_valid pulses with matching data, 5 SLRD pulses, SLOE falls, back to IDLE.
- Write message: 3 words 0xA001..0xA003, tx_last on the 3rd -> 3 SLWR pulses with FD matching, 3 tx_ready pulses, FIFOADR=10, one PKTEND 1 cycle after the last SLWR falls.
- Back-pressure: FLAG_FULL=1 after the 2nd write word for 10 cycles -> stays in WR_GAP, no SLWR or tx_ready, then resumes with word 3.
- Fairness: MAX_BURST=4, both sides continuously pending -> alternating grants of 4 reads / 4 writes, never more than 4 words per grant.
- With FX2_PKTEND_TIMEOUT_EN, PKT_TIMEOUT=16: write 2 words without tx_last, then go idle -> single PKTEND pulse 16 cycles later. Without the macro: no PKTEND.

Source files
------------

// File: rtl/fx2_slave_fifo_arb_if.sv
// Pin/handshake bundle between the FX2 slave-FIFO controller and its surroundings.
// master = controller side, slave = FX2 flags plus local TX FIFO / RX parser.
interface fx2_slave_fifo_arb_if #(
  parameter int DW = 16
);
  logic          FLAG_EMPTY;
  logic          FLAG_FULL;
  logic          SLOE;
  logic          SLRD;
  logic          SLWR;
  logic          PKTEND;
  logic [1:0]    FIFOADR;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_last;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;

  modport master (
    input  FLAG_EMPTY, FLAG_FULL, tx_data, tx_valid, tx_last,
    output SLOE, SLRD, SLWR, PKTEND, FIFOADR, tx_ready, rx_data, rx_valid
  );

  modport slave (
    output FLAG_EMPTY, FLAG_FULL, tx_data, tx_valid, tx_last,
    input  SLOE, SLRD, SLWR, PKTEND, FIFOADR, tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/fx2_slave_fifo_arb.sv
// FX2 slave-FIFO controller: round-robin bounded read/write bursts with PKTEND commit.
// Optional idle-timeout PKTEND for short packets: define FX2_PKTEND_TIMEOUT_EN.
module fx2_slave_fifo_arb #(
  parameter int         DW          = 16,
  parameter logic [1:0] RD_EP_ADR   = 2'b00,
  parameter logic [1:0] WR_EP_ADR   = 2'b10,
  parameter int         MAX_BURST   = 256,
  parameter int         PKT_TIMEOUT = 1024
) (
  input  logic                       CLK,
  input  logic                       RST,
  inout  wire  [DW-1:0]              FD,
  fx2_slave_fifo_arb_if.master       bus,
  output logic [2:0]                 state_monitor
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_OE  = 3'd1,
    RD_CHK = 3'd2,
    RD_STB = 3'd3,
    WR_STB = 3'd4,
    WR_GAP = 3'd5,
    PKT    = 3'd6
  } state_t;

  localparam logic [15:0] MAX_CNT = 16'(MAX_BURST);

  state_t        state_reg;
  logic [15:0]   cnt_reg;
  logic          last_grant_reg;   // 1 = previous grant was the write side
  logic          last_word_reg;    // tx_last captured with the word in out_reg
  logic [DW-1:0] out_reg;
  logic          drive_reg;
  logic          sloe_reg;
  logic          slrd_reg;
  logic          slwr_reg;
  logic          pktend_reg;
  logic [1:0]    fifoadr_reg;
  logic          tx_ready_reg;
  logic [DW-1:0] rx_data_reg;
  logic          rx_valid_reg;

  logic          rd_req;
  logic          wr_req;
  logic          grant_rd;
  logic          grant_wr;
  logic          cnt_below_max;
  logic [15:0]   cnt_inc;
  logic          tmo_fire;

  assign rd_req        = !bus.FLAG_EMPTY;
  assign wr_req        = !bus.FLAG_FULL && bus.tx_valid;
  assign grant_rd      = rd_req && (!wr_req || last_grant_reg);
  assign grant_wr      = wr_req && (!rd_req || !last_grant_reg);
  assign cnt_below_max = (cnt_reg < MAX_CNT);
  assign cnt_inc       = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;

  assign FD            = drive_reg ? out_reg : {DW{1'bz}};

  assign bus.SLOE      = sloe_reg;
  assign bus.SLRD      = slrd_reg;
  assign bus.SLWR      = slwr_reg;
  assign bus.PKTEND    = pktend_reg;
  assign bus.FIFOADR   = fifoadr_reg;
  assign bus.tx_ready  = tx_ready_reg;
  assign bus.rx_data   = rx_data_reg;
  assign bus.rx_valid  = rx_valid_reg;
  assign state_monitor = state_reg;

`ifdef FX2_PKTEND_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(PKT_TIMEOUT - 1);

  logic [15:0] tmo_cnt_reg;
  logic        tmo_pend_reg;   // a word without tx_last is sitting uncommitted in the FX2

  assign tmo_fire = tmo_pend_reg && (tmo_cnt_reg >= TMO_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tmo_cnt_reg  <= 16'd0;
      tmo_pend_reg <= 1'b0;
    end else if (slwr_reg) begin
      tmo_cnt_reg  <= 16'd0;
      tmo_pend_reg <= !last_word_reg;
    end else if (state_reg == PKT) begin
      tmo_cnt_reg  <= 16'd0;
      tmo_pend_reg <= 1'b0;
    end else if (state_reg == IDLE && tmo_pend_reg && !tmo_fire) begin
      tmo_cnt_reg  <= tmo_cnt_reg + 16'd1;
    end
  end
`else
  // Never true for a legal configuration; the idle timeout is compiled out.
  assign tmo_fire = (PKT_TIMEOUT < 0);
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg      <= IDLE;
      cnt_reg        <= 16'd0;
      last_grant_reg <= 1'b1;
      last_word_reg  <= 1'b0;
      out_reg        <= '0;
      drive_reg      <= 1'b0;
      sloe_reg       <= 1'b0;
      slrd_reg       <= 1'b0;
      slwr_reg       <= 1'b0;
      pktend_reg     <= 1'b0;
      fifoadr_reg    <= RD_EP_ADR;
      tx_ready_reg   <= 1'b0;
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
    end else begin
      tx_ready_reg <= 1'b0;
      rx_valid_reg <= 1'b0;
      pktend_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_rd) begin
            fifoadr_reg    <= RD_EP_ADR;
            cnt_reg        <= 16'd0;
            last_grant_reg <= 1'b0;
            state_reg      <= RD_OE;
          end else if (grant_wr) begin
            fifoadr_reg    <= WR_EP_ADR;
            out_reg        <= bus.tx_data;
            last_word_reg  <= bus.tx_last;
            tx_ready_reg   <= 1'b1;
            slwr_reg       <= 1'b1;
            drive_reg      <= 1'b1;
            cnt_reg        <= 16'd1;
            last_grant_reg <= 1'b1;
            state_reg      <= WR_STB;
          end else if (tmo_fire) begin
            state_reg      <= PKT;
          end
        end
        RD_OE: begin
          // FIFOADR settles for a cycle before the FX2 is allowed onto FD.
          sloe_reg  <= 1'b1;
          state_reg <= RD_CHK;
        end
        RD_CHK: begin
          if (!bus.FLAG_EMPTY && cnt_below_max) begin
            rx_data_reg  <= FD;
            rx_valid_reg <= 1'b1;
            slrd_reg     <= 1'b1;
            state_reg    <= RD_STB;
          end else begin
            sloe_reg     <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        RD_STB: begin
          slrd_reg  <= 1'b0;
          cnt_reg   <= cnt_inc;
          state_reg <= RD_CHK;
        end
        WR_STB: begin
          slwr_reg <= 1'b0;
          if (last_word_reg) begin
            drive_reg <= 1'b0;
            state_reg <= PKT;
          end else begin
            state_reg <= WR_GAP;
          end
        end
        WR_GAP: begin
          // A full endpoint freezes the burst here; nothing moves until space returns.
          if (!bus.FLAG_FULL) begin
            if (bus.tx_valid && cnt_below_max) begin
              out_reg       <= bus.tx_data;
              last_word_reg <= bus.tx_last;
              tx_ready_reg  <= 1'b1;
              slwr_reg      <= 1'b1;
              cnt_reg       <= cnt_inc;
              state_reg     <= WR_STB;
            end else begin
              drive_reg     <= 1'b0;
              state_reg     <= IDLE;
            end
          end
        end
        PKT: begin
          pktend_reg <= 1'b1;
          state_reg  <= IDLE;
        end
        default: begin
          drive_reg <= 1'b0;
          sloe_reg  <= 1'b0;
          slrd_reg  <= 1'b0;
          slwr_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fx2_slave_fifo_arb.sv
// Bench for fx2_slave_fifo_arb: FX2 endpoint and local TX FIFO models with a word scoreboard,
// arbitration-rule reference, and directed reset / burst / back-pressure / timeout scenarios.
module tb_fx2_slave_fifo_arb;
  localparam int         DW     = 16;
  localparam int         MAXB   = 4;
  localparam int         TMO    = 16;
  localparam logic [1:0] RD_ADR = 2'b00;
  localparam logic [1:0] WR_ADR = 2'b10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  wire  [DW-1:0] fd;
  logic [DW-1:0] fx2_word;
  logic [2:0]    state_mon;

  fx2_slave_fifo_arb_if #(.DW(DW)) bus ();

  fx2_slave_fifo_arb #(
    .DW(DW), .RD_EP_ADR(RD_ADR), .WR_EP_ADR(WR_ADR),
    .MAX_BURST(MAXB), .PKT_TIMEOUT(TMO)
  ) dut (
    .CLK(clk), .RST(rst), .FD(fd), .bus(bus), .state_monitor(state_mon)
  );

  always #5 clk = ~clk;
  assign fd = bus.SLOE ? fx2_word : {DW{1'bz}};

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] fx2q[$];   // OUT endpoint contents, head is the next word FD presents
  logic [DW:0]   txq[$];    // local TX FIFO, {last, data}

  int cyc = 0, rx_total = 0, slrd_total = 0, wr_total = 0;
  int pkt_commit = 0, pkt_tmo = 0, tx_pushed = 0, last_pushed = 0, fx2_pushed = 0;
  int last_slwr_cyc = -100;
  bit last_slwr_last = 1'b0;
  bit rand_full = 0, rand_empty = 0, rand_txgap = 0;
  int full_hold = 0, bp_after = -1, bp_cnt = 0, burst = 0;
  bit last_g_wr = 1'b1;
  bit prev_valid = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0, prev_full = 1'b0;
  logic [2:0] prev_st = 3'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic observe();
    logic [2:0] st;
    bit exp_wr;
    st = state_mon;
    if (prev_valid && prev_st == 3'd0 && (prev_rd || prev_wr)) begin
      exp_wr = (prev_rd && prev_wr) ? !last_g_wr : prev_wr;
      check_eq("grant", 32'(st), exp_wr ? 32'd4 : 32'd1);
      last_g_wr = exp_wr;
      burst = 0;
    end
    if (bus.SLRD || bus.rx_valid) check_eq("rd_pair", 32'(bus.SLRD), 32'(bus.rx_valid));
    if (bus.rx_valid) rx_total++;
    if (bus.SLRD) begin
      slrd_total++;
      burst++;
      check_eq("rd_oe", 32'(bus.SLOE), 32'd1);
      check_eq("rd_burst_le_max", 32'(burst <= MAXB), 32'd1);
      check_eq("rd_avail", 32'(fx2q.size() != 0), 32'd1);
      if (fx2q.size() != 0) begin
        $display("[%0d] rd %h", cyc, bus.rx_data);
        check_eq("rx_data", 32'(bus.rx_data), 32'(fx2q[0]));
        void'(fx2q.pop_front());
      end
    end
    if (bus.SLWR || bus.tx_ready) check_eq("wr_pair", 32'(bus.SLWR), 32'(bus.tx_ready));
    if (bus.SLWR) begin
      wr_total++;
      burst++;
      check_eq("wr_no_sloe", 32'(bus.SLOE), 32'd0);
      check_eq("wr_adr", 32'(bus.FIFOADR), 32'(WR_ADR));
      check_eq("wr_burst_le_max", 32'(burst <= MAXB), 32'd1);
      if (prev_valid) check_eq("wr_not_full", 32'(prev_full), 32'd0);
      check_eq("wr_avail", 32'(txq.size() != 0), 32'd1);
      if (txq.size() != 0) begin
        $display("[%0d] wr %h last=%0d", cyc, fd, txq[0][DW]);
        check_eq("wr_data", 32'(fd), 32'(txq[0][DW-1:0]));
        last_slwr_last = txq[0][DW];
        void'(txq.pop_front());
      end
      last_slwr_cyc = cyc;
      if (bp_after >= 0 && wr_total == bp_after) begin
        full_hold = 10;
        bp_after  = -1;
      end
    end
    if (prev_valid && prev_full && prev_st == 3'd5) begin
      bp_cnt++;
      check_eq("bp_hold", 32'(st), 32'd5);
    end
    if (bus.PKTEND) begin
      $display("[%0d] pktend", cyc);
      if (last_slwr_last && cyc == last_slwr_cyc + 2) begin
        pkt_commit++;
        last_slwr_last = 1'b0;
      end else begin
        pkt_tmo++;
`ifdef FX2_PKTEND_TIMEOUT_EN
        check_eq("pkt_timeout_gap", 32'(cyc - last_slwr_cyc >= TMO), 32'd1);
`else
        check_eq("pkt_unexpected", 32'(pkt_tmo), 32'd0);
`endif
      end
    end
  endtask

  task automatic drive_inputs();
    bus.FLAG_FULL = (full_hold > 0) || (rand_full && $urandom_range(0, 3) == 0);
    if (full_hold > 0) full_hold--;
    bus.FLAG_EMPTY = (fx2q.size() == 0) || (rand_empty && $urandom_range(0, 3) == 0);
    fx2_word = (fx2q.size() != 0) ? fx2q[0] : '0;
    if (txq.size() != 0) begin
      bus.tx_valid = !(rand_txgap && $urandom_range(0, 3) == 0);
      bus.tx_data  = txq[0][DW-1:0];
      bus.tx_last  = txq[0][DW];
    end else begin
      bus.tx_valid = 1'b0;
      bus.tx_last  = 1'b0;
    end
  endtask

  // FX2 + TX FIFO model: outputs are observed and inputs updated on the falling edge.
  initial begin
    fx2_word       = '0;
    bus.FLAG_EMPTY = 1'b1;
    bus.FLAG_FULL  = 1'b0;
    bus.tx_valid   = 1'b0;
    bus.tx_data    = '0;
    bus.tx_last    = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        last_g_wr = 1'b1;
        burst     = 0;
      end else begin
        observe();
      end
      drive_inputs();
      prev_valid = rst;
      prev_st    = state_mon;
      prev_rd    = !bus.FLAG_EMPTY;
      prev_wr    = !bus.FLAG_FULL && bus.tx_valid;
      prev_full  = bus.FLAG_FULL;
    end
  end

  task automatic push_msg(input logic [DW-1:0] base, input int n, input bit with_last);
    logic lb;
    for (int i = 0; i < n; i++) begin
      lb = with_last && (i == n - 1);
      txq.push_back({lb, DW'(base + DW'(i))});
      tx_pushed++;
      if (lb) last_pushed++;
    end
  endtask

  task automatic wait_drain(input string tag);
    int quiet;
    bit done;
    quiet = 0;
    done  = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      #1;
      if (fx2q.size() == 0 && txq.size() == 0 && state_mon == 3'd0 && !bus.PKTEND) quiet++;
      else quiet = 0;
      if (quiet >= 4) done = 1'b1;
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int base_tmo;
    bit found;

    // Reset held with both sides pending.
    for (int i = 1; i <= 5; i++) begin
      fx2q.push_back(DW'(16'h1111 * i));
      fx2_pushed++;
    end
    push_msg(16'hA001, 3, 1'b1);
    repeat (4) @(negedge clk);
    #1;
    check_eq("rst_sloe", 32'(bus.SLOE), 32'd0);
    check_eq("rst_slrd", 32'(bus.SLRD), 32'd0);
    check_eq("rst_slwr", 32'(bus.SLWR), 32'd0);
    check_eq("rst_pktend", 32'(bus.PKTEND), 32'd0);
    check_eq("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
    check_eq("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check_eq("rst_rx_data", 32'(bus.rx_data), 32'd0);
    check_eq("rst_fifoadr", 32'(bus.FIFOADR), 32'(RD_ADR));
    check_eq("rst_state", 32'(state_mon), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("first_grant_read", 32'(state_mon), 32'd1);
    check_eq("first_grant_adr", 32'(bus.FIFOADR), 32'(RD_ADR));
    wait_drain("drain_basic");
    check_eq("basic_rx_count", 32'(rx_total), 32'd5);
    check_eq("basic_slrd_count", 32'(slrd_total), 32'd5);
    check_eq("basic_wr_count", 32'(wr_total), 32'd3);
    check_eq("basic_pktend", 32'(pkt_commit), 32'd1);
    check_eq("basic_sloe_low", 32'(bus.SLOE), 32'd0);

    // Asynchronous reset in the middle of a read burst.
    for (int i = 0; i < 6; i++) begin
      fx2q.push_back(DW'(16'h2000 + i));
      fx2_pushed++;
    end
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      #1;
      if (bus.SLRD) found = 1'b1;
    end
    check_eq("abort_slrd_seen", 32'(found), 32'd1);
    #1 rst = 1'b0;
    #1;
    check_eq("abort_slrd", 32'(bus.SLRD), 32'd0);
    check_eq("abort_sloe", 32'(bus.SLOE), 32'd0);
    check_eq("abort_rx_valid", 32'(bus.rx_valid), 32'd0);
    check_eq("abort_state", 32'(state_mon), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    wait_drain("drain_abort");

    // Write back-pressure: endpoint full for 10 cycles after the second word.
    bp_cnt   = 0;
    bp_after = wr_total + 2;
    push_msg(16'hB001, 4, 1'b1);
    wait_drain("drain_bp");
    check_eq("bp_cycles", 32'(bp_cnt), 32'd9);

    // Message left open: only the idle timeout may commit it.
    base_tmo = pkt_tmo;
    push_msg(16'hC001, 2, 1'b0);
    wait_drain("drain_tmo");
    repeat (2 * TMO + 10) @(negedge clk);
`ifdef FX2_PKTEND_TIMEOUT_EN
    check_eq("tmo_pktend", 32'(pkt_tmo - base_tmo), 32'd1);
`else
    check_eq("tmo_none", 32'(pkt_tmo - base_tmo), 32'd0);
`endif

    // Randomized mixed traffic with flag noise and TX gaps.
    rand_full  = 1'b1;
    rand_empty = 1'b1;
    rand_txgap = 1'b1;
    repeat (40) begin
      for (int i = 0; i < int'($urandom_range(1, 9)); i++) begin
        fx2q.push_back(DW'($urandom));
        fx2_pushed++;
      end
      push_msg(DW'($urandom), int'($urandom_range(1, 7)), 1'b1);
      repeat ($urandom_range(5, 40)) @(negedge clk);
    end
    rand_full  = 1'b0;
    rand_empty = 1'b0;
    rand_txgap = 1'b0;
    wait_drain("drain_random");

    check_eq("total_rx", 32'(rx_total), 32'(fx2_pushed));
    check_eq("total_slrd", 32'(slrd_total), 32'(fx2_pushed));
    check_eq("total_wr", 32'(wr_total), 32'(tx_pushed));
    check_eq("total_pkt_commit", 32'(pkt_commit), 32'(last_pushed));
`ifndef FX2_PKTEND_TIMEOUT_EN
    check_eq("total_pkt_spurious", 32'(pkt_tmo), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
